icache_refill_unit: RTL and testbench

- Fills one instruction cache line on behalf of the execute stage.
- Accepts a line refill command carrying the line's virtual and physical address.
- Issues 8 word reads on the instruction memory bus and collects the in-order responses into a line buffer.
- Drives the fetch stage cache port (cache_port_addr/cache_port_data/cache_port_set) for the write. It sits between the execute stage's miss handling and the fetch stage's instruction cache.

---
 rtl/icache_refill_unit_if.sv | 21 ++
 rtl/icache_refill_unit.sv | 136 +++++++++++++
 tb/tb_icache_refill_unit.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_refill_unit_if.sv
// Instruction memory read bus: the refill unit is the master, the memory is the slave.
interface icache_refill_unit_if #(
    parameter int PLEN = 56
);
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [PLEN-1:0] mem_req_addr;
    logic            mem_resp_valid;
    logic [31:0]     mem_resp_data;
    logic            mem_resp_error;

    modport master (
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_error
    );

    modport slave (
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_error
    );
endinterface

// File: rtl/icache_refill_unit.sv
// Refills one 8-word instruction cache line from the memory bus and writes it to the fetch stage.
// state | meaning
// IDLE  | waiting for a refill command
// FETCH | issuing word reads and collecting in-order responses
// WRITE | presenting the line to the fetch stage until it is sampled (stall=0)
module icache_refill_unit #(
    parameter int VLEN           = 39,
    parameter int PLEN           = 56,
    parameter int WORDS_PER_LINE = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            stall,
    input  logic                            refill_req,
    input  logic [VLEN-6:0]                 refill_vaddr,
    input  logic [PLEN-6:0]                 refill_paddr,
    input  logic                            refill_abort,
    output logic                            refill_busy,
    output logic                            refill_done,
    output logic                            refill_error,
    icache_refill_unit_if.master            mem,
    output logic [VLEN-6:0]                 cache_port_addr,
    output logic [WORDS_PER_LINE-1:0][31:0] cache_port_data,
    output logic                            cache_port_set
);
    typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;

    state_t                          state_q, state_d;
    logic [VLEN-6:0]                 vaddr_q;
    logic [PLEN-6:0]                 paddr_q;
    logic [3:0]                      req_cnt_q, req_cnt_d;
    logic [3:0]                      resp_cnt_q, resp_cnt_d;
    logic                            err_q, err_d;
    logic                            abort_q, abort_d;
    logic                            done_d, error_d;
    logic                            load;
    logic                            req_fire, resp_fire, abort_now;
    logic [WORDS_PER_LINE-1:0][31:0] line_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d           = state_q;
        req_cnt_d         = req_cnt_q;
        resp_cnt_d        = resp_cnt_q;
        err_d             = err_q;
        abort_d           = abort_q;
        done_d            = 1'b0;
        error_d           = 1'b0;
        load              = 1'b0;
        req_fire          = 1'b0;
        resp_fire         = 1'b0;
        abort_now         = abort_q || refill_abort;
        mem.mem_req_valid = 1'b0;
        cache_port_set    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (refill_req) begin
                    load       = 1'b1;
                    req_cnt_d  = '0;
                    resp_cnt_d = '0;
                    err_d      = 1'b0;
                    abort_d    = 1'b0;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                mem.mem_req_valid = (req_cnt_q < 4'(WORDS_PER_LINE)) && !abort_now;
                req_fire          = mem.mem_req_valid && mem.mem_req_ready;
                // a response with nothing outstanding is a protocol violation and is dropped
                resp_fire         = mem.mem_resp_valid && (resp_cnt_q < req_cnt_q);
                if (req_fire) req_cnt_d = req_cnt_q + 4'd1;
                if (resp_fire) begin
                    resp_cnt_d = resp_cnt_q + 4'd1;
                    err_d      = err_q | mem.mem_resp_error;
                end
                if (refill_abort) abort_d = 1'b1;
                if (abort_now) begin
                    if (resp_cnt_d == req_cnt_d) state_d = IDLE;
                end else if (resp_fire && resp_cnt_q == 4'(WORDS_PER_LINE - 1)) begin
                    if (err_d) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                cache_port_set = !refill_abort;
                if (refill_abort) begin
                    state_d = IDLE;
                end else if (!stall) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vaddr_q      <= '0;
            paddr_q      <= '0;
            req_cnt_q    <= '0;
            resp_cnt_q   <= '0;
            err_q        <= 1'b0;
            abort_q      <= 1'b0;
            refill_done  <= 1'b0;
            refill_error <= 1'b0;
            line_q       <= '0;
        end else begin
            req_cnt_q    <= req_cnt_d;
            resp_cnt_q   <= resp_cnt_d;
            err_q        <= err_d;
            abort_q      <= abort_d;
            refill_done  <= done_d;
            refill_error <= error_d;
            if (load) begin
                vaddr_q <= refill_vaddr;
                paddr_q <= refill_paddr;
            end
            if (resp_fire) line_q[resp_cnt_q[2:0]] <= mem.mem_resp_data;
        end
    end

    assign refill_busy      = (state_q != IDLE);
    assign mem.mem_req_addr = {paddr_q, req_cnt_q[2:0], 2'b00};
    assign cache_port_addr  = vaddr_q;
    assign cache_port_data  = line_q;
endmodule

// File: tb/tb_icache_refill_unit.sv
// Directed and randomized checks of icache_refill_unit against a word-level memory and line model.
module tb_icache_refill_unit;
    localparam int VLEN = 39;
    localparam int PLEN = 56;

    logic                  clock, reset, stall, refill_req, refill_abort;
    logic [VLEN-6:0]       refill_vaddr;
    logic [PLEN-6:0]       refill_paddr;
    logic                  refill_busy, refill_done, refill_error, cache_port_set;
    logic [VLEN-6:0]       cache_port_addr;
    logic [7:0][31:0]      cache_port_data;

    icache_refill_unit_if #(.PLEN(PLEN)) mem ();

    icache_refill_unit #(.VLEN(VLEN), .PLEN(PLEN), .WORDS_PER_LINE(8)) dut (
        .clock(clock), .reset(reset), .stall(stall),
        .refill_req(refill_req), .refill_vaddr(refill_vaddr), .refill_paddr(refill_paddr),
        .refill_abort(refill_abort), .refill_busy(refill_busy), .refill_done(refill_done),
        .refill_error(refill_error), .mem(mem.master), .cache_port_addr(cache_port_addr),
        .cache_port_data(cache_port_data), .cache_port_set(cache_port_set)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0, n_bad = 0;
    int cyc, gcyc;
    int ready_mode, min_delay, max_extra, err_idx, stall_n, abort_fetch_en, abort_wr_at;
    logic force_abort;
    logic [PLEN-1:0] pend_addr[$];
    int              pend_due[$];
    logic [PLEN-1:0] req_log[$];
    int              req_cyc[$];
    int n_resp, last_resp_cyc, n_set, n_writes, n_done, done_cyc, first_set_cyc, idle_cyc;
    int hold_bad, wr_hold_bad;
    logic last_err, abort_fired, valid_at_abort, set_at_abort, hold_pend;
    logic [PLEN-1:0]  hold_addr;
    logic [VLEN-6:0]  wr_addr, first_addr;
    logic [7:0][31:0] wr_data, first_data;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // backing store: word at byte address a
    function automatic logic [31:0] mem_word(input logic [PLEN-1:0] a);
        return 32'hA000_0003 + a[33:2] - 32'h0040_0000;
    endfunction

    function automatic logic [7:0][31:0] line_of(input logic [PLEN-6:0] p);
        logic [7:0][31:0] l;
        for (int i = 0; i < 8; i++) l[i] = mem_word({p, 3'(i), 2'b00});
        return l;
    endfunction

    task automatic env(input int rm, input int mind, input int maxe, input int eidx,
                       input int sn, input int afe, input int awa);
        ready_mode = rm; min_delay = mind; max_extra = maxe; err_idx = eidx;
        stall_n = sn; abort_fetch_en = afe; abort_wr_at = awa;
    endtask

    // one clock cycle of environment: drive inputs, settle, observe, advance
    task automatic tick();
        logic pre_set;
        pre_set = cache_port_set;
        case (ready_mode)
            0:       mem.mem_req_ready = 1'b1;
            1:       mem.mem_req_ready = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
            default: mem.mem_req_ready = 1'($urandom_range(0, 1));
        endcase
        refill_abort = force_abort;
        if (abort_fetch_en != 0 && !abort_fired && req_log.size() == 3 && n_resp == 1) begin
            refill_abort = 1'b1; abort_fired = 1'b1;
        end
        if (abort_wr_at > 0 && pre_set && n_set == abort_wr_at - 1) begin
            refill_abort = 1'b1; abort_fired = 1'b1;
        end
        stall = (n_set < stall_n);
        if (pend_addr.size() > 0 && pend_due[0] <= gcyc) begin
            mem.mem_resp_valid = 1'b1;
            mem.mem_resp_data  = mem_word(pend_addr[0]);
            mem.mem_resp_error = (n_resp == err_idx);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
            n_resp++;
            last_resp_cyc = cyc;
        end else begin
            mem.mem_resp_valid = 1'b0;
            mem.mem_resp_data  = $urandom;
            mem.mem_resp_error = 1'($urandom_range(0, 1));
        end
        #1;
        if (mem.mem_req_valid) begin
            if (hold_pend && mem.mem_req_addr !== hold_addr) hold_bad++;
            if (mem.mem_req_ready) begin
                pend_addr.push_back(mem.mem_req_addr);
                pend_due.push_back(gcyc + min_delay + int'($urandom_range(0, max_extra)));
                req_log.push_back(mem.mem_req_addr);
                req_cyc.push_back(cyc);
                hold_pend = 1'b0;
            end else begin
                hold_pend = 1'b1;
                hold_addr = mem.mem_req_addr;
            end
        end else begin
            hold_pend = 1'b0;
        end
        if (refill_abort) begin
            valid_at_abort = mem.mem_req_valid;
            set_at_abort   = cache_port_set;
        end
        if (cache_port_set) begin
            if (n_set == 0) begin
                first_set_cyc = cyc; first_addr = cache_port_addr; first_data = cache_port_data;
            end else if (cache_port_addr !== first_addr || cache_port_data !== first_data) begin
                wr_hold_bad++;
            end
            n_set++;
            if (!stall) begin
                n_writes++; wr_addr = cache_port_addr; wr_data = cache_port_data;
            end
        end
        if (refill_done) begin
            n_done++; done_cyc = cyc; last_err = refill_error;
        end
        @(posedge clock);
        #1;
        cyc++;
        gcyc++;
    endtask

    task automatic start_refill(input logic [VLEN-6:0] v, input logic [PLEN-6:0] p, input logic with_abort);
        req_log.delete(); req_cyc.delete();
        n_set = 0; n_writes = 0; n_done = 0; done_cyc = -1; first_set_cyc = -1; idle_cyc = -1;
        hold_bad = 0; wr_hold_bad = 0; hold_pend = 1'b0; abort_fired = 1'b0;
        valid_at_abort = 1'b1; set_at_abort = 1'b1; last_err = 1'b0;
        wr_data = '0; wr_addr = '0; first_data = '0; first_addr = '0;
        cyc = 0;
        refill_vaddr = v; refill_paddr = p; refill_req = 1'b1; force_abort = with_abort;
        tick();
        refill_req = 1'b0; force_abort = 1'b0;
        // anything still queued belongs to a refill that no longer exists
        pend_addr.delete(); pend_due.delete();
        n_resp = 0; last_resp_cyc = -1;
    endtask

    task automatic finish_refill(input int bound, input string tag);
        for (int k = 0; k < bound && refill_busy; k++) tick();
        idle_cyc = cyc;
        check({tag, "_timeout_busy"}, refill_busy, 1'b0);
        repeat (3) tick();
    endtask

    task automatic check_addrs(input string tag, input logic [PLEN-6:0] p);
        check({tag, "_nreq"}, req_log.size(), 8);
        for (int i = 0; i < 8; i++)
            check({tag, "_addr"}, (i < req_log.size()) ? req_log[i] : 'x, {p, 3'(i), 2'b00});
    endtask

    logic [VLEN-6:0] v;
    logic [PLEN-6:0] p;
    int eidx;

    initial begin
        reset = 1'b1; stall = 1'b0; refill_req = 1'b0; refill_abort = 1'b0; force_abort = 1'b0;
        refill_vaddr = '0; refill_paddr = '0;
        mem.mem_req_ready = 1'b0; mem.mem_resp_valid = 1'b0;
        mem.mem_resp_data = '0; mem.mem_resp_error = 1'b0;
        cyc = 0; gcyc = 0; n_resp = 0;
        env(0, 1, 0, -1, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", refill_busy, 1'b0);
        check("rst_done", refill_done, 1'b0);
        check("rst_error", refill_error, 1'b0);
        check("rst_valid", mem.mem_req_valid, 1'b0);
        check("rst_set", cache_port_set, 1'b0);
        check("rst_addr", mem.mem_req_addr, '0);
        check("rst_cpaddr", cache_port_addr, '0);
        check("rst_cpdata", cache_port_data, '0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // abort alone in IDLE does nothing
        force_abort = 1'b1; tick(); force_abort = 1'b0;
        check("idle_abort_busy", refill_busy, 1'b0);

        // 1: zero-wait refill, exact latency
        env(0, 1, 0, -1, 0, 0, 0);
        start_refill(34'h100, 51'h80000, 1'b0);
        finish_refill(40, "t1");
        check_addrs("t1", 51'h80000);
        for (int i = 0; i < 8; i++)
            check("t1_reqcyc", (i < req_cyc.size()) ? req_cyc[i] : -1, i + 1);
        check("t1_setcyc", first_set_cyc, 10);
        check("t1_donecyc", done_cyc, 11);
        check("t1_writes", n_writes, 1);
        check("t1_ndone", n_done, 1);
        check("t1_err", last_err, 1'b0);
        check("t1_wraddr", wr_addr, 34'h100);
        check("t1_word0", wr_data[0], 32'hA000_0003);
        check("t1_word7", wr_data[7], 32'hA000_000A);
        check("t1_line", wr_data, line_of(51'h80000));

        // 2: backpressure 1,0,0,1 and randomly delayed responses
        env(1, 1, 3, -1, 0, 0, 0);
        v = 34'({$urandom, $urandom}); p = 51'({$urandom, $urandom});
        start_refill(v, p, 1'b0);
        finish_refill(200, "t2");
        check_addrs("t2", p);
        check("t2_hold", hold_bad, 0);
        check("t2_writes", n_writes, 1);
        check("t2_nset", n_set, 1);
        check("t2_line", wr_data, line_of(p));
        check("t2_wraddr", wr_addr, v);
        check("t2_err", {n_done[7:0], last_err}, {8'd1, 1'b0});

        // 3: bus error on 3rd response, then on the 8th
        for (int k = 0; k < 2; k++) begin
            env(2, 1, 2, (k == 0) ? 2 : 7, 0, 0, 0);
            p = 51'({$urandom, $urandom});
            start_refill(34'h2A5, p, 1'b0);
            finish_refill(200, "t3");
            check("t3_nresp", n_resp, 8);
            check("t3_nset", n_set, 0);
            check("t3_ndone", n_done, 1);
            check("t3_err", last_err, 1'b1);
            check("t3_donecyc", done_cyc, last_resp_cyc + 1);
        end

        // 4: abort after 3 requests and 1 response
        env(0, 2, 0, -1, 0, 1, 0);
        start_refill(34'h33, 51'h1234, 1'b0);
        finish_refill(40, "t4");
        check("t4_fired", abort_fired, 1'b1);
        check("t4_valid_at_abort", valid_at_abort, 1'b0);
        check("t4_nreq", req_log.size(), 3);
        check("t4_nresp", n_resp, 3);
        check("t4_idlecyc", idle_cyc, last_resp_cyc + 1);
        check("t4_ndone", n_done, 0);
        check("t4_nset", n_set, 0);

        // 5: stall 4 cycles in WRITE, then abort on the 2nd stalled cycle
        env(0, 1, 0, -1, 4, 0, 0);
        p = 51'({$urandom, $urandom});
        start_refill(34'h77, p, 1'b0);
        finish_refill(60, "t5a");
        check("t5a_nset", n_set, 5);
        check("t5a_stable", wr_hold_bad, 0);
        check("t5a_writes", n_writes, 1);
        check("t5a_donecyc", done_cyc, first_set_cyc + 5);
        check("t5a_err", last_err, 1'b0);
        check("t5a_line", wr_data, line_of(p));
        env(0, 1, 0, -1, 4, 0, 2);
        start_refill(34'h78, p, 1'b0);
        finish_refill(60, "t5b");
        check("t5b_set_at_abort", set_at_abort, 1'b0);
        check("t5b_nset", n_set, 1);
        check("t5b_ndone", n_done, 0);
        check("t5b_idlecyc", idle_cyc, first_set_cyc + 2);

        // request and abort together in IDLE: request wins
        env(0, 1, 0, -1, 0, 0, 0);
        start_refill(34'h5, 51'h99, 1'b1);
        finish_refill(40, "tra");
        check("tra_writes", n_writes, 1);
        check("tra_done", {n_done[7:0], last_err}, {8'd1, 1'b0});

        // 6: async reset after 5 responses, stale responses, fresh refill
        env(0, 1, 0, -1, 0, 0, 0);
        start_refill(34'h11, 51'h4444, 1'b0);
        for (int k = 0; k < 40 && n_resp < 5; k++) tick();
        check("t6_resp5", n_resp, 5);
        reset = 1'b1;
        mem.mem_resp_valid = 1'b1; mem.mem_resp_data = 32'hDEAD_BEEF;
        #1;
        check("t6_busy", refill_busy, 1'b0);
        check("t6_valid", mem.mem_req_valid, 1'b0);
        check("t6_set", cache_port_set, 1'b0);
        check("t6_done", refill_done, 1'b0);
        check("t6_addr", mem.mem_req_addr, '0);
        check("t6_cpdata", cache_port_data, '0);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        gcyc++;
        p = 51'h5A5A5;
        start_refill(34'h22, p, 1'b0);
        finish_refill(40, "t6");
        check_addrs("t6", p);
        check("t6_setcyc", first_set_cyc, 10);
        check("t6_line", wr_data, line_of(p));
        check("t6_wraddr", wr_addr, 34'h22);
        check("t6_ndone", {n_done[7:0], last_err}, {8'd1, 1'b0});

        // randomized refills
        for (int it = 0; it < 4; it++) begin
            eidx = $urandom_range(0, 11);
            env(2, $urandom_range(1, 3), $urandom_range(0, 3), eidx, $urandom_range(0, 2), 0, 0);
            v = 34'({$urandom, $urandom}); p = 51'({$urandom, $urandom});
            start_refill(v, p, 1'b0);
            finish_refill(300, "rnd");
            check_addrs("rnd", p);
            check("rnd_hold", hold_bad, 0);
            check("rnd_nresp", n_resp, 8);
            check("rnd_ndone", n_done, 1);
            check("rnd_err", last_err, eidx < 8);
            check("rnd_writes", n_writes, (eidx < 8) ? 0 : 1);
            if (eidx >= 8) check("rnd_line", wr_data, line_of(p));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
